// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall code -> gate pair, dead time on every change, PWM on high sides, fault trip.
// Gates registered (1 cycle from pwm_i); optional brake via BLDC_COMM_BRAKE_EN.
module bldc_commutator #(
  parameter int DEAD_TIME = 8,
  parameter int STALL_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic [2:0]         hall_data_i,
  input  logic               hall_change_i,
  input  logic               pwm_i,
  input  logic [STALL_W-1:0] stall_limit_i,
  input  logic               fault_clr_i,
`ifdef BLDC_COMM_BRAKE_EN
  input  logic               brake_i,
`endif
  output logic [5:0]         gate_o,
  output logic [1:0]         state_o,
  output logic               fault_o,
  output logic               stall_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DEAD  = 2'd1;
  localparam logic [1:0] S_DRIVE = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;
  localparam logic [5:0] BRAKE_PAT = 6'b010101;
  localparam logic [7:0] DEAD_LOAD = 8'(DEAD_TIME);

  logic [1:0]         r_state, w_state_nxt;
  logic [5:0]         r_pat, r_gate, w_tgt_pat, w_drv_pat;
  logic               r_dir, r_brake, r_fault, r_stall_flag;
  logic [7:0]         r_dead;
  logic [STALL_W-1:0] r_stall_cnt, w_stall_inc;
  logic               w_hall_ok, w_brake, w_stall_hit, w_resume;
  logic               w_latch, w_fault_set, w_fault_cause, w_fault_clr;

  function automatic logic [5:0] f_pattern(input logic [2:0] hall, input logic dir);
    logic [5:0] fwd;
    case (hall)
      3'd5:    fwd = 6'b100100;
      3'd4:    fwd = 6'b100001;
      3'd6:    fwd = 6'b001001;
      3'd2:    fwd = 6'b011000;
      3'd3:    fwd = 6'b010010;
      3'd1:    fwd = 6'b000110;
      default: fwd = 6'b000000;
    endcase
    // Reverse swaps high and low switch within every phase.
    return dir ? {fwd[4], fwd[5], fwd[2], fwd[3], fwd[0], fwd[1]} : fwd;
  endfunction

`ifdef BLDC_COMM_BRAKE_EN
  assign w_brake = brake_i;
`else
  assign w_brake = 1'b0;
`endif

  assign w_hall_ok   = (hall_data_i != 3'd0) && (hall_data_i != 3'd7);
  assign w_resume    = en_i && w_hall_ok;
  assign w_tgt_pat   = w_brake ? BRAKE_PAT : f_pattern(hall_data_i, dir_i);
  assign w_drv_pat   = r_pat & {pwm_i, 1'b1, pwm_i, 1'b1, pwm_i, 1'b1};
  assign w_stall_inc = (&r_stall_cnt) ? r_stall_cnt : r_stall_cnt + STALL_W'(1);
  assign w_stall_hit = (stall_limit_i != '0) && (w_stall_inc == stall_limit_i);

  always_comb begin
    w_state_nxt   = r_state;
    w_latch       = 1'b0;
    w_fault_set   = 1'b0;
    w_fault_cause = 1'b0;
    w_fault_clr   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_brake || w_resume) begin
          w_latch     = 1'b1;
          w_state_nxt = S_DEAD;
        end
      end
      S_DEAD: begin
        if (w_brake != r_brake) begin
          // Brake toggled mid-gap: retarget and restart the full gap.
          if (w_brake || w_resume) w_latch = 1'b1;
          else                     w_state_nxt = S_IDLE;
        end else if (!r_brake && !en_i) begin
          w_state_nxt = S_IDLE;
        end else if (r_dead <= 8'd1) begin
          w_state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (r_brake) begin
          if (!w_brake) begin
            if (w_resume) begin
              w_latch     = 1'b1;
              w_state_nxt = S_DEAD;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end else if (!w_hall_ok) begin
          w_fault_set = 1'b1;
          w_state_nxt = S_FAULT;
        end else if (w_stall_hit && !hall_change_i) begin
          w_fault_set   = 1'b1;
          w_fault_cause = 1'b1;
          w_state_nxt   = S_FAULT;
        end else if (w_brake) begin
          w_latch     = 1'b1;
          w_state_nxt = S_DEAD;
        end else if (!en_i) begin
          w_state_nxt = S_IDLE;
        end else if ((hall_change_i || (dir_i != r_dir)) && (w_tgt_pat != r_pat)) begin
          w_latch     = 1'b1;
          w_state_nxt = S_DEAD;
        end
      end
      default: begin
        if (fault_clr_i && !en_i) begin
          w_fault_clr = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_pat        <= '0;
      r_dir        <= 1'b0;
      r_brake      <= 1'b0;
      r_dead       <= '0;
      r_stall_cnt  <= '0;
      r_fault      <= 1'b0;
      r_stall_flag <= 1'b0;
      r_gate       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_latch) begin
        r_pat   <= w_tgt_pat;
        r_dir   <= dir_i;
        r_brake <= w_brake;
        r_dead  <= DEAD_LOAD;
      end else if (r_state == S_DEAD && r_dead != 8'd0) begin
        r_dead <= r_dead - 8'd1;
      end
      // Held at zero outside DRIVE, so DRIVE always starts from a cleared count.
      if (r_state != S_DRIVE || hall_change_i) r_stall_cnt <= '0;
      else                                     r_stall_cnt <= w_stall_inc;
      if (w_fault_set) begin
        r_fault      <= 1'b1;
        r_stall_flag <= w_fault_cause;
      end else if (w_fault_clr) begin
        r_fault      <= 1'b0;
        r_stall_flag <= 1'b0;
      end
      r_gate <= (w_state_nxt == S_DRIVE) ? w_drv_pat : 6'b000000;
    end
  end

  assign gate_o  = r_gate;
  assign state_o = r_state;
  assign fault_o = r_fault;
  assign stall_o = r_stall_flag;

endmodule

// File: doc/bldc_commutator.md
Name: bldc_commutator

Overview:
- Six-step commutation sequencer for a three-phase BLDC bridge.
- Consumes the debounced hall code and its change pulse from the hall capture stage.
- Selects the active high-side/low-side switch pair, inserts dead time on every pair change, gates high sides with the PWM carrier, and trips to a safe state on an invalid hall code or a rotor stall.
- Sits between the hall capture stage and the bridge gate-drive pins; configured from the BLDC register block.

Parameters:
DEAD_TIME, 8, dead-time length in clk cycles (1..255); all gates off for this many cycles on every pattern change
STALL_W, 16, width of the stall counter and the stall_limit_i port

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-high
en_i  input  1  drive enable from control register
dir_i  input  1  0 = forward, 1 = reverse
hall_data_i  input  3  stable hall code (valid codes 1..6)
hall_change_i  input  1  one-cycle pulse: new hall code latched
pwm_i  input  1  PWM carrier; ANDed into high-side gates
stall_limit_i  input  STALL_W  cycles without a hall change before stall fault; 0 disables stall detection
fault_clr_i  input  1  clears sticky fault
gate_o  output  6  {UH,UL,VH,VL,WH,WL}, registered
state_o  output  2  0 IDLE, 1 DEAD, 2 DRIVE, 3 FAULT
fault_o  output  1  sticky fault flag
stall_o  output  1  fault cause: 1 = stall, 0 = invalid hall

Behaviour:
- Reset: state IDLE; gate_o = 0, fault_o = 0, stall_o = 0; dead and stall counters = 0; latched pattern = 0.
- Forward table, hall code -> (high side, low side):
  - 5 -> (U, V); 4 -> (U, W); 6 -> (V, W)
  - 2 -> (V, U); 3 -> (W, U); 1 -> (W, V)
- Reverse: same table with the high and low sides swapped.
- At most one high-side and one low-side gate are active at once; never both switches of the same phase.
- IDLE:
  - gate_o = 0.
  - If en_i = 1 and hall code is valid: latch the pattern for {hall_data_i, dir_i}, load the dead counter with DEAD_TIME, go to DEAD.
  - If en_i = 1 and hall code is invalid: stay in IDLE, no fault.
- DEAD:
  - gate_o = 0; the dead counter decrements each cycle.
  - Exits to DRIVE on the cycle after the counter reaches 1, so there are exactly DEAD_TIME cycles with gates off.
  - en_i = 0 -> IDLE.
- DRIVE:
  - gate_o low side = latched pattern; gate_o high side = latched pattern AND pwm_i. Gate outputs are registered, 1-cycle latency from pwm_i.
  - Pattern change: hall_change_i with a valid code, or any dir_i change, recomputes the pattern. If it differs from the latched pattern: latch it, reload the dead counter, go to DEAD. If it is identical: stay in DRIVE.
  - Invalid hall code (0 or 7), checked every cycle: go to FAULT with stall_o = 0. This takes priority over commutation.
  - Stall counter: cleared on entry to DRIVE and on every hall_change_i; otherwise increments, saturating at all-ones. If stall_limit_i != 0 and the counter equals stall_limit_i: go to FAULT with stall_o = 1.
  - en_i = 0 -> IDLE; gates are 0 on the next cycle. en_i = 0 has priority over every DRIVE transition except FAULT.
- FAULT:
  - gate_o = 0; fault_o = 1.
  - Leaves only when fault_clr_i = 1 and en_i = 0: go to IDLE and clear fault_o and stall_o.
  - fault_clr_i with en_i = 1 is ignored.
- The stall counter does not run in DEAD, so the dead time never counts toward a stall.
- Simultaneous hall_change_i and stall match in the same cycle: the hall change wins and the counter clears.
- A mid-operation rst assertion forces gates off immediately (asynchronous).

Optional Feature:
- Macro: BLDC_COMM_BRAKE_EN.
- Defined:
  - Adds input brake_i (1 bit).
  - While brake_i = 1 in IDLE, DRIVE or DEAD: after a full DEAD_TIME gap, gate_o = 6'b010101 (all low sides on, no PWM gating); state_o reports DRIVE.
  - Release of brake_i inserts dead time before normal drive resumes.
  - FAULT overrides brake.
- Undefined: no brake_i port; the brake logic is absent.

Test Plan:
- Reset; en_i = 1, dir_i = 0, hall = 5, pwm_i = 1, DEAD_TIME = 8 -> 8 cycles gate_o = 0, then gate_o = 6'b100100, state_o = 2.
- In DRIVE, hall 5 -> 4 with pulse -> 8 dead cycles, then 6'b100001; toggle pwm_i -> bit 5 follows one cycle later, bit 0 stays set.
- dir_i = 1 with hall = 5 while driving -> dead gap, then 6'b011000 (VH, UL).
- hall forced to 7 in DRIVE -> next cycle gate_o = 0, fault_o = 1, stall_o = 0. fault_clr_i with en_i = 1 -> no change. fault_clr_i with en_i = 0 -> IDLE, fault_o = 0.
- stall_limit_i = 100 with no hall pulses -> FAULT, stall_o = 1, exactly 100 cycles after DRIVE entry. Repeat with a pulse every 50 cycles -> no fault.
- Under BLDC_COMM_BRAKE_EN: brake_i = 1 while driving -> 8 dead cycles, then 6'b010101; brake_i = 0 -> dead gap, then resumes the hall pattern.
